// File: rtl/alu_seq_if.sv
// Handshake bundle for alu_seq: operand/opcode request channel and result/flag channel.
// The master drives requests and accepts results; the slave is the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [3:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic             err;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, opcode, out_ready,
    input  in_ready, out_valid, out_result, carry, overflow, zero, err, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, opcode, out_ready,
    output in_ready, out_valid, out_result, carry, overflow, zero, err, busy
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU with iterative unsigned multiply/divide/remainder, one operation in flight.
// IDLE accepts, CALC evaluates (one cycle for simple ops, WIDTH steps plus a finish cycle otherwise), DONE holds the result.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_NOT  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_EQ   = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_DIVU = 4'd9;
  localparam logic [3:0] OP_REMU = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_iter(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]       a_q, b_q;
  logic [3:0]             op_q;
  logic [2*WIDTH-1:0]     prod_q, prod_d;

  logic [WIDTH-1:0]       res_q, res_d;
  logic                   carry_q, carry_d;
  logic                   ovf_q, ovf_d;
  logic                   zero_q, zero_d;
  logic                   err_q, err_d;

  logic                   accept;
  logic                   last;
  logic                   step;

  assign accept = bus.in_valid && (state_q == S_IDLE);
  // Simple ops finish on their first CALC cycle; iterative ops after WIDTH steps.
  assign last   = !is_iter(op_q) || (cnt_q == CNT_W'(WIDTH));
  assign step   = (state_q == S_CALC) && !last;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_CALC;
          cnt_d   = '0;
        end
      end
      S_CALC: begin
        if (last) state_d = S_DONE;
        else      cnt_d   = cnt_q + CNT_W'(1);
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Iterative datapath: prod_q holds {acc_hi, multiplier} for MUL, {remainder, dividend/quotient} for divide.
  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;
  logic           div_ok;

  assign mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? a_q : {WIDTH{1'b0}})};
  assign div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_ok    = !div_diff[WIDTH];

  always_comb begin
    prod_d = prod_q;
    if (accept) begin
      prod_d = {{WIDTH{1'b0}}, ((bus.opcode == OP_MUL) ? bus.in_b : bus.in_a)};
    end else if (step) begin
      if (op_q == OP_MUL) begin
        prod_d = {mul_sum, prod_q[WIDTH-1:1]};
      end else if (div_ok) begin
        prod_d = {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
      end else begin
        prod_d = {div_shift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    prod_q <= prod_d;
    if (accept) begin
      a_q  <= bus.in_a;
      b_q  <= bus.in_b;
      op_q <= bus.opcode;
    end
  end

  // Result and flag evaluation
  logic [WIDTH:0]          add_w;
  logic [WIDTH:0]          sub_w;
  logic signed [WIDTH-1:0] a_s, b_s;

  assign add_w = {1'b0, a_q} + {1'b0, b_q};
  assign sub_w = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);
  assign a_s   = a_q;
  assign b_s   = b_q;

  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    err_d   = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_d   = add_w[WIDTH-1:0];
        carry_d = add_w[WIDTH];
        ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        res_d   = sub_w[WIDTH-1:0];
        carry_d = !sub_w[WIDTH];
        ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_NOT: res_d = ~a_q;
      OP_AND: res_d = a_q & b_q;
      OP_OR:  res_d = a_q | b_q;
      OP_XOR: res_d = a_q ^ b_q;
      OP_SLT: res_d = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      OP_EQ:  res_d = {{(WIDTH-1){1'b0}}, (a_q == b_q)};
      OP_MUL: begin
        res_d   = prod_q[WIDTH-1:0];
        carry_d = |prod_q[2*WIDTH-1:WIDTH];
      end
      OP_DIVU: begin
        err_d = (b_q == '0);
        res_d = (b_q == '0) ? {WIDTH{1'b1}} : prod_q[WIDTH-1:0];
      end
      OP_REMU: begin
        err_d = (b_q == '0);
        res_d = (b_q == '0) ? a_q : prod_q[2*WIDTH-1:WIDTH];
      end
      default: err_d = 1'b1;
    endcase
    zero_d = (res_d == '0);
  end

  // Result register: loaded only on the CALC->DONE transition
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if ((state_q == S_CALC) && last) begin
      res_q   <= res_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  // Output logic
  always_comb begin
    bus.in_ready   = (state_q == S_IDLE);
    bus.out_valid  = (state_q == S_DONE);
    bus.busy       = (state_q != S_IDLE);
    bus.out_result = res_q;
    bus.carry      = carry_q;
    bus.overflow   = ovf_q;
    bus.zero       = zero_q;
    bus.err        = err_q;
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8: single-cycle ops, iterative ops, backpressure and async reset.
module tb_alu_seq;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  alu_seq_if #(.WIDTH(8)) bus ();

  alu_seq #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int g;
    g = 0;
    while (!bus.in_ready && g < 50) begin
      tick();
      g++;
    end
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.in_a     = a;
    bus.in_b     = b;
    tick();
    bus.in_valid = 1'b0;
    bus.in_a     = 8'hA5;
    bus.in_b     = 8'h5A;
    bus.opcode   = 4'd0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] er, input logic ec, input logic ev, input logic ez,
                     input logic ee, input int elat);
    int lat;
    bus.out_ready = 1'b1;
    issue(op, a, b);
    wait_done(lat);
    chk({tag, "_lat"},   lat, elat);
    chk({tag, "_res"},   bus.out_result, er);
    chk({tag, "_carry"}, bus.carry, ec);
    chk({tag, "_ovf"},   bus.overflow, ev);
    chk({tag, "_zero"},  bus.zero, ez);
    chk({tag, "_err"},   bus.err, ee);
    tick();
    chk({tag, "_pulse"}, bus.out_valid, 1'b0);
    chk({tag, "_rdy"},   bus.in_ready, 1'b1);
  endtask

  initial begin
    int lat;
    tests = 0;
    fails = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.opcode    = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready",  bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_busy",      bus.busy, 1'b0);
    chk("rst_result",    bus.out_result, 8'h00);
    chk("rst_flags",     {bus.carry, bus.overflow, bus.zero, bus.err}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    tick();

    //   tag     op     a      b      res    c     v     z     e     lat
    run("add",  4'd0,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    run("addc", 4'd0,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    run("sub",  4'd1,  8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    run("subv", 4'd1,  8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    run("not",  4'd2,  8'h0F, 8'h00, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    run("and",  4'd3,  8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    run("or",   4'd4,  8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    run("xor",  4'd5,  8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    run("slt",  4'd6,  8'h80, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    run("sltn", 4'd6,  8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    run("eq",   4'd7,  8'h5A, 8'h5A, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    run("ill",  4'd12, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1);
    run("mulc", 4'd8,  8'h10, 8'h20, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 9);
    run("mul",  4'd8,  8'h0C, 8'h0B, 8'h84, 1'b0, 1'b0, 1'b0, 1'b0, 9);
    run("divu", 4'd9,  8'hC8, 8'h07, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 9);
    run("remu", 4'd10, 8'hC8, 8'h07, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 9);
    run("div0", 4'd9,  8'h55, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 9);
    run("rem0", 4'd10, 8'h55, 8'h00, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 9);

    // Backpressure: hold the result while a second request waits
    bus.out_ready = 1'b0;
    issue(4'd0, 8'd3, 8'd4);
    wait_done(lat);
    chk("bp_lat", lat, 1);
    bus.in_valid = 1'b1;
    bus.opcode   = 4'd0;
    bus.in_a     = 8'h09;
    bus.in_b     = 8'h09;
    for (int i = 0; i < 5; i++) begin
      chk("bp_res",   bus.out_result, 8'h07);
      chk("bp_flags", {bus.carry, bus.overflow, bus.zero, bus.err}, 4'b0000);
      chk("bp_ctl",   {bus.in_ready, bus.busy, bus.out_valid}, 3'b011);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release", {bus.in_ready, bus.out_valid}, 2'b10);
    tick();
    chk("bp_accept2", {bus.in_ready, bus.busy}, 2'b01);
    bus.in_valid = 1'b0;
    tick();
    chk("bp_valid2", bus.out_valid, 1'b1);
    chk("bp_res2",   bus.out_result, 8'h12);
    tick();

    // Asynchronous reset in the 3rd CALC cycle of a multiply
    bus.out_ready = 1'b1;
    issue(4'd8, 8'h0C, 8'h0B);
    tick();
    tick();
    chk("ar_busy_before", bus.busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("ar_in_ready",  bus.in_ready, 1'b1);
    chk("ar_out_valid", bus.out_valid, 1'b0);
    chk("ar_busy",      bus.busy, 1'b0);
    chk("ar_result",    bus.out_result, 8'h00);
    chk("ar_flags",     {bus.carry, bus.overflow, bus.zero, bus.err}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 12; i++) begin
      chk("ar_no_pulse", bus.out_valid, 1'b0);
      tick();
    end
    run("ar_add", 4'd0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
